// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle controller and the RV32I datapath.
// master = controller side, slave = datapath side.
interface multicycle_ctrl_if;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        zero;
  logic        mem_ready;
  logic        mem_req;
  logic        adr_src;
  logic        mem_write;
  logic        ir_write;
  logic        pc_write;
  logic        reg_write;
  logic [1:0]  alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  alu_op;
  logic [1:0]  result_src;
  logic        instr_done;
  logic [31:0] retired;
  logic [3:0]  state;

  modport master (
    input  op, funct3, zero, mem_ready,
    output mem_req, adr_src, mem_write, ir_write, pc_write, reg_write,
           alu_src_a, alu_src_b, alu_op, result_src, instr_done, retired, state
  );

  modport slave (
    output op, funct3, zero, mem_ready,
    input  mem_req, adr_src, mem_write, ir_write, pc_write, reg_write,
           alu_src_a, alu_src_b, alu_op, result_src, instr_done, retired, state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Moore-style main controller for the multi-cycle RV32I core, with wait states and retire count.
// Optional: CTRL_ILLEGAL_TRAP_EN sends unknown opcodes to a sticky HALT state.
module multicycle_ctrl (
  input logic              clk,
  input logic              reset,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    StFetch    = 4'h0,
    StDecode   = 4'h1,
    StMemAdr   = 4'h2,
    StMemRead  = 4'h3,
    StMemWb    = 4'h4,
    StMemWrite = 4'h5,
    StExecR    = 4'h6,
    StExecI    = 4'h7,
    StAluWb    = 4'h8,
    StBranch   = 4'h9,
    StJal      = 4'hA,
    StJalr     = 4'hB,
    StLui      = 4'hC,
    StHalt     = 4'hD
  } state_e;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;

  state_e      state_q, state_d;
  logic        jalr_q, jalr_d;
  logic [31:0] retired_q;
  logic        ir_we, pc_we, reg_we, mem_we, done;

  logic unused_funct3;
  assign unused_funct3 = ^bus.funct3[2:1];

  always_comb begin
    state_d        = state_q;
    jalr_d         = jalr_q;
    ir_we          = 1'b0;
    pc_we          = 1'b0;
    reg_we         = 1'b0;
    mem_we         = 1'b0;
    done           = 1'b0;
    bus.mem_req    = 1'b0;
    bus.adr_src    = 1'b0;
    bus.alu_src_a  = 2'b00;
    bus.alu_src_b  = 2'b00;
    bus.alu_op     = 2'b00;
    bus.result_src = 2'b00;
    unique case (state_q)
      StFetch: begin
        bus.mem_req    = 1'b1;
        bus.alu_src_b  = 2'b10;
        bus.result_src = 2'b10;
        if (bus.mem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = StDecode;
        end
      end
      StDecode: begin
        // ALUOut captures oldPC + imm as the branch/jal target
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b01;
        case (bus.op)
          OpLoad, OpStore: state_d = StMemAdr;
          OpReg:           state_d = StExecR;
          OpImm:           state_d = StExecI;
          OpBranch:        state_d = StBranch;
          OpJal:           state_d = StJal;
          OpJalr:          state_d = StJalr;
          OpLui:           state_d = StLui;
          default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            state_d = StHalt;
`else
            state_d = StFetch;
            done    = 1'b1;
`endif
          end
        endcase
      end
      StMemAdr: begin
        bus.alu_src_a = 2'b10;
        bus.alu_src_b = 2'b01;
        state_d       = (bus.op == OpStore) ? StMemWrite : StMemRead;
      end
      StMemRead: begin
        bus.mem_req = 1'b1;
        bus.adr_src = 1'b1;
        if (bus.mem_ready) state_d = StMemWb;
      end
      StMemWb: begin
        bus.result_src = 2'b01;
        reg_we         = 1'b1;
        done           = 1'b1;
        state_d        = StFetch;
      end
      StMemWrite: begin
        bus.mem_req = 1'b1;
        bus.adr_src = 1'b1;
        mem_we      = 1'b1;
        if (bus.mem_ready) begin
          done    = 1'b1;
          state_d = StFetch;
        end
      end
      StExecR: begin
        bus.alu_src_a = 2'b10;
        bus.alu_op    = 2'b10;
        state_d       = StAluWb;
      end
      StExecI: begin
        bus.alu_src_a = 2'b10;
        bus.alu_src_b = 2'b01;
        bus.alu_op    = 2'b10;
        state_d       = StAluWb;
      end
      StAluWb: begin
        reg_we  = 1'b1;
        done    = 1'b1;
        state_d = StFetch;
      end
      StBranch: begin
        bus.alu_src_a = 2'b10;
        bus.alu_op    = 2'b01;
        pc_we         = bus.zero ^ bus.funct3[0];
        done          = 1'b1;
        state_d       = StFetch;
      end
      StJal: begin
        // Reused after JALR only to form the link value; PC was already loaded
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b10;
        pc_we         = ~jalr_q;
        jalr_d        = 1'b0;
        state_d       = StAluWb;
      end
      StJalr: begin
        bus.alu_src_a  = 2'b10;
        bus.alu_src_b  = 2'b01;
        bus.result_src = 2'b10;
        pc_we          = 1'b1;
        jalr_d         = 1'b1;
        state_d        = StJal;
      end
      StLui: begin
        bus.alu_src_a = 2'b11;
        bus.alu_src_b = 2'b01;
        state_d       = StAluWb;
      end
      StHalt: state_d = StHalt;
      default: state_d = StFetch;
    endcase
  end

  // Reset cycle must never commit architectural state
  assign bus.ir_write   = ir_we  & ~reset;
  assign bus.pc_write   = pc_we  & ~reset;
  assign bus.reg_write  = reg_we & ~reset;
  assign bus.mem_write  = mem_we & ~reset;
  assign bus.instr_done = done   & ~reset;
  assign bus.retired    = retired_q;
  assign bus.state      = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StFetch;
      jalr_q    <= 1'b0;
      retired_q <= 32'd0;
    end else begin
      state_q <= state_d;
      jalr_q  <= jalr_d;
      if (bus.instr_done) retired_q <= retired_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: per-instruction cycle counts, enable counts and retire
// count checked against an instruction-level model.
module tb_multicycle_ctrl;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpBad    = 7'b1111111;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;
  logic [31:0] model_retired = 32'd0;

  multicycle_ctrl_if bus ();

  multicycle_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic int base_latency(input logic [6:0] opc);
    case (opc)
      OpLoad, OpJalr:               return 5;
      OpStore, OpReg, OpImm, OpJal,
      OpLui:                        return 4;
      OpBranch:                     return 3;
      default:                      return 2;
    endcase
  endfunction

  function automatic bit writes_reg(input logic [6:0] opc);
    return opc inside {OpLoad, OpReg, OpImm, OpJal, OpJalr, OpLui};
  endfunction

  // One instruction from FETCH to retirement; memory answers after wf / wm wait cycles
  task automatic run_instr(input logic [6:0] opc, input logic [2:0] f3, input logic z,
                           input int wf, input int wm);
    int cycles = 0, n_ir = 0, n_pc = 0, n_reg = 0, n_mw = 0;
    int fetch_left = wf, data_left = wm;
    bit in_fetch = 1'b1, done = 1'b0, taken;
    logic [1:0] rs_reg = 2'b11, rs_pc = 2'b11;
    int exp_pc;
    bus.op = opc; bus.funct3 = f3; bus.zero = z;
    check_eq($sformatf("start_state op=%b", opc), {28'd0, bus.state}, 32'h0);
    while (!done && cycles < 40) begin
      if (bus.mem_req) begin
        if (in_fetch) begin
          bus.mem_ready = (fetch_left == 0);
          if (fetch_left == 0) in_fetch = 1'b0; else fetch_left--;
        end else begin
          bus.mem_ready = (data_left == 0);
          if (data_left != 0) data_left--;
        end
      end else begin
        bus.mem_ready = 1'($urandom_range(0, 1));
      end
      #1;
      cycles++;
      if (bus.ir_write)  n_ir++;
      if (bus.mem_write) n_mw++;
      if (bus.pc_write)  begin n_pc++;  rs_pc  = bus.result_src; end
      if (bus.reg_write) begin n_reg++; rs_reg = bus.result_src; end
      done = bus.instr_done;
      @(posedge clk); #1;
    end
    model_retired++;
    taken  = (opc == OpBranch) && (z ^ f3[0]);
    exp_pc = 1 + ((taken || opc == OpJal || opc == OpJalr) ? 1 : 0);
    check_eq($sformatf("retire_seen op=%b", opc), {31'd0, done}, 32'd1);
    check_eq($sformatf("cycles op=%b", opc), cycles,
             base_latency(opc) + wf + ((opc == OpLoad || opc == OpStore) ? wm : 0));
    check_eq($sformatf("ir_write_cnt op=%b", opc), n_ir, 1);
    check_eq($sformatf("pc_write_cnt op=%b", opc), n_pc, exp_pc);
    check_eq($sformatf("reg_write_cnt op=%b", opc), n_reg, writes_reg(opc) ? 1 : 0);
    check_eq($sformatf("mem_write_cnt op=%b", opc), n_mw, (opc == OpStore) ? wm + 1 : 0);
    if (writes_reg(opc))
      check_eq($sformatf("wb_src op=%b", opc), {30'd0, rs_reg},
               (opc == OpLoad) ? 32'd1 : 32'd0);
    check_eq($sformatf("pc_src op=%b", opc), {30'd0, rs_pc},
             (opc == OpJalr || exp_pc == 1) ? 32'd2 : 32'd0);
    check_eq($sformatf("retired op=%b", opc), bus.retired, model_retired);
  endtask

  task automatic check_no_writes(input string tag);
    check_eq(tag, {28'd0, bus.ir_write, bus.pc_write, bus.reg_write, bus.mem_write}, 32'd0);
  endtask

  logic [6:0] op_tab [9];
  initial begin
    int steps;
    logic [6:0] opc;
    logic [2:0] f3;
    op_tab = '{OpLoad, OpStore, OpReg, OpImm, OpBranch, OpJal, OpJalr, OpLui, OpBad};
    bus.op = OpReg; bus.funct3 = 3'd0; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_no_writes($sformatf("reset_we_%0d", i));
    end
    reset = 1'b0;
    check_eq("reset_state", {28'd0, bus.state}, 32'h0);
    check_eq("reset_retired", bus.retired, 32'd0);

    run_instr(OpLoad, 3'd2, 1'b0, 0, 2);
    run_instr(OpBranch, 3'b000, 1'b1, 0, 0);
    run_instr(OpBranch, 3'b001, 1'b1, 0, 0);
    run_instr(OpJalr, 3'd0, 1'b0, 0, 0);

    for (int n = 0; n < 60; n++) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
      opc = op_tab[$urandom_range(0, 7)];
`else
      opc = op_tab[$urandom_range(0, 8)];
`endif
      f3 = (opc == OpBranch) ? 3'($urandom_range(0, 1)) : 3'($urandom_range(0, 7));
      run_instr(opc, f3, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    bus.op = OpBad; bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_eq("halt_state", {28'd0, bus.state}, 32'hD);
    for (int i = 0; i < 3; i++) begin
      bus.mem_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      check_eq("halt_sticky", {28'd0, bus.state}, 32'hD);
      check_no_writes("halt_we");
    end
    check_eq("halt_retired", bus.retired, model_retired);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_retired = 32'd0;
`else
    run_instr(OpBad, 3'd0, 1'b0, 1, 0);
`endif

    // Abandon a store mid-wait with reset
    bus.op = OpStore; bus.mem_ready = 1'b1;
    steps = 0;
    while (bus.state != 4'h5 && steps < 10) begin
      @(posedge clk); #1;
      steps++;
    end
    check_eq("reach_memwrite", {28'd0, bus.state}, 32'h5);
    bus.mem_ready = 1'b0;
    #1;
    check_eq("memwrite_strobe", {31'd0, bus.mem_write}, 32'd1);
    reset = 1'b1;
    #1;
    check_eq("reset_kills_strobe", {31'd0, bus.mem_write}, 32'd0);
    check_eq("reset_no_done", {31'd0, bus.instr_done}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    model_retired = 32'd0;
    check_eq("abandon_state", {28'd0, bus.state}, 32'h0);
    check_eq("abandon_retired", bus.retired, model_retired);
    run_instr(OpLui, 3'd0, 1'b0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle main controller for the RV32I datapath: a registered Moore FSM that sequences instruction fetch, decode, execute, memory access and writeback over a shared ALU, one memory port, the instruction register and the immediate extender. It replaces single-cycle control in the multi-cycle core and sits between the instruction register (`op`/`funct3`) and the datapath mux and enable inputs. It also handles memory wait states and counts retired instructions.

## Interface
- No parameters.
- `clk` in 1: the design's single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `op` in 7: instr[6:0] from the instruction register.
- `funct3` in 3: instr[14:12].
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completes the current access this cycle.
- `mem_req` out 1: memory access active.
- `adr_src` out 1: 0 = PC, 1 = ALUOut.
- `mem_write` out 1: store strobe.
- `ir_write` out 1: load the instruction register and oldPC.
- `pc_write` out 1: PC load enable.
- `reg_write` out 1: register file write enable.
- `alu_src_a` out 2: 00 = PC, 01 = oldPC, 10 = rs1, 11 = zero.
- `alu_src_b` out 2: 00 = rs2, 01 = immext, 10 = constant 4.
- `alu_op` out 2: 00 = add, 01 = subtract/compare, 10 = decode funct.
- `result_src` out 2: 00 = ALUOut, 01 = read data, 10 = ALU result.
- `instr_done` out 1: one-cycle pulse per retired instruction.
- `retired` out 32: retired-instruction count.
- `state` out 4: current state, for debug.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR, LUI, HALT.
- Any output not listed for a state is 0.
- **FETCH**
  - Drives `mem_req`=1, `adr_src`=0, A=00, B=10, `alu_op`=00, `result_src`=10.
  - `ir_write` and `pc_write` assert only when `mem_ready`=1.
  - Stays in FETCH while `mem_ready`=0; goes to DECODE when `mem_ready`=1.
- **DECODE**
  - Drives A=01, B=01, `alu_op`=00, so ALUOut = branch/jal target.
  - Next state by opcode:
    - LOAD 0000011 → MEMADR; STORE 0100011 → MEMADR.
    - OP 0110011 → EXECR; OP-IMM 0010011 → EXECI.
    - BRANCH 1100011 → BRANCH.
    - JAL 1101111 → JAL; JALR 1100111 → JALR; LUI 0110111 → LUI.
    - Any other opcode: see Configuration.
- **MEMADR**: A=10, B=01, `alu_op`=00. Goes to MEMREAD for a load, MEMWRITE for a store.
- **MEMREAD**: `mem_req`=1, `adr_src`=1. Holds until `mem_ready`, then goes to MEMWB.
- **MEMWB**: `result_src`=01, `reg_write`=1, then FETCH.
- **MEMWRITE**
  - `mem_req`=1, `adr_src`=1, `mem_write`=1, held stable until `mem_ready`.
  - On `mem_ready`, goes to FETCH.
- **EXECR**: A=10, B=00, `alu_op`=10, then ALUWB.
- **EXECI**: A=10, B=01, `alu_op`=10, then ALUWB.
- **ALUWB**: `result_src`=00, `reg_write`=1, then FETCH.
- **BRANCH**
  - A=10, B=00, `alu_op`=01, `result_src`=00.
  - `pc_write` = `zero` XOR `funct3[0]` (beq/bne).
  - Goes to FETCH.
- **JAL**: A=01, B=10, `result_src`=00, `pc_write`=1, so PC = target and ALUOut = oldPC+4. Then ALUWB.
- **JALR**: A=10, B=01, `result_src`=10, `pc_write`=1, so PC = rs1+imm. Then EXECJ behaviour:
  - JALR is followed by the JAL state (A=01, B=10, `pc_write` forced 0 via an internal flag), then ALUWB.
- **LUI**: A=11, B=01, `alu_op`=00, then ALUWB.
- **Retirement**
  - `instr_done` pulses in the cycle the FSM leaves MEMWB, ALUWB, MEMWRITE (with `mem_ready`) or BRANCH.
  - `retired` increments by 1 on each `instr_done` and wraps from 0xFFFFFFFF to 0.

## Timing
- Reset:
  - `state` = FETCH, `retired` = 0, internal JALR flag cleared.
  - During the reset cycle all write enables (`ir_write`, `pc_write`, `reg_write`, `mem_write`) are forced 0.
- Reset mid-instruction abandons the instruction; no `instr_done` and no writes occur in the reset cycle.
- Outputs are combinational from `state` plus `mem_ready`/`zero`/`funct3`; there are no registered outputs except `retired`.
- Latency with zero wait states:
  - load 5 cycles; store 4; R/I 4; branch 3; jal 4; jalr 5; lui 4.
- Each `mem_ready`=0 cycle in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- `mem_ready` outside a `mem_req` state is ignored.

## Configuration
- `CTRL_ILLEGAL_TRAP_EN`
  - Defined: an unknown opcode in DECODE moves to HALT.
  - HALT asserts all enables 0 and stays there until `reset`; `state` reads the HALT code 4'hD.
  - Not defined: an unknown opcode returns to FETCH with `instr_done` pulsed (executed as a NOP), and the HALT state is unreachable.

## Test plan
- Reset held for 3 cycles, then released, with `mem_ready`=1 → `state`=FETCH, `retired`=0, no write enable asserted in any reset cycle.
- LW (op 0000011) with `mem_ready` low for 2 cycles in MEMREAD → 7 cycles FETCH→FETCH; `reg_write` for exactly 1 cycle with `result_src`=01.
- BEQ with `zero`=1 → `pc_write`=1 in BRANCH. BNE (`funct3`=001) with `zero`=1 → `pc_write`=0. Both retire in 3 cycles.
- JALR → `pc_write` with `result_src`=10, then ALUWB `reg_write`; `pc_write` asserted exactly twice per instruction (FETCH, JALR).
- `reset` asserted in MEMWRITE while `mem_ready`=0 → `mem_write` low the same cycle, FETCH next, `retired` = 0.
- Opcode 1111111 → HALT (`state`=4'hD) with the macro defined; without it, FETCH after DECODE and `retired`+1.
